// File: rtl/io_exec.sv
// Two-word instruction sequencer moving words between a RAM and an in/out port pair (IN, OUT, HLT).
// Optional feature: define IO_EXEC_TRAP_EN to stop on illegal opcodes; otherwise they execute as 2-word NOPs.
module io_exec #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted,
  output logic                  trap
);

  localparam logic [4:0] OP_IN  = 5'b01011;
  localparam logic [4:0] OP_OUT = 5'b01100;
  localparam logic [4:0] OP_HLT = 5'b01111;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_ADR,
    IN_WAIT,
    OUT_RD,
    OUT_WAIT,
    HALT,
    TRAP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [4:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;

  // The RAM writes on the same edge that ends IN_WAIT, so the write strobe is decoded, not registered.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mem_addr  = pc;
    mem_wdata = in_data;
    mem_we    = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IN_WAIT: begin
        mem_addr = operand;
        in_ready = 1'b1;
        mem_we   = in_valid;
      end
      OUT_RD:  mem_addr = operand;
      default: ;
    endcase
  end

  // NOTE: all state updates here use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_OP;
      pc        <= START_ADDR;
      opcode    <= '0;
      operand   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
`ifdef IO_EXEC_TRAP_EN
      trap      <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH_OP: begin
          if (run) begin
            opcode <= mem_q[15:11];
            pc     <= pc + PC_STEP;
            state  <= FETCH_ADR;
          end
        end
        FETCH_ADR: begin
          // The operand word is consumed for every opcode, HLT and illegal ones included.
          operand <= mem_q[ADDR_WIDTH-1:0];
          pc      <= pc + PC_STEP;
          case (opcode)
            OP_IN:  state <= IN_WAIT;
            OP_OUT: state <= OUT_RD;
            OP_HLT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: begin
`ifdef IO_EXEC_TRAP_EN
              state <= TRAP;
              trap  <= 1'b1;
`else
              state <= FETCH_OP;
`endif
            end
          endcase
        end
        IN_WAIT: begin
          if (in_valid) state <= FETCH_OP;
        end
        OUT_RD: begin
          out_data  <= mem_q;
          out_valid <= 1'b1;
          state     <= OUT_WAIT;
        end
        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FETCH_OP;
          end
        end
        HALT: state <= HALT;
`ifdef IO_EXEC_TRAP_EN
        TRAP: state <= TRAP;
`endif
        default: state <= FETCH_OP;
      endcase
    end
  end

`ifndef IO_EXEC_TRAP_EN
  assign trap = 1'b0;
`endif

endmodule

// File: doc/io_exec.md
IO_EXEC -- requirements
Module: io_exec

Interface
REQ-001 Parameter DATA_WIDTH, default 16: memory word and I/O data width.
REQ-002 Parameter ADDR_WIDTH, default 16: memory address width.
REQ-003 Parameter START_ADDR, default 0: program counter value after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  execution enable; sampled only in FETCH_OP.
REQ-007 mem_addr  output  ADDR_WIDTH  address to the RAM.
REQ-008 mem_wdata  output  DATA_WIDTH  write data to the RAM.
REQ-009 mem_we  output  1  RAM write enable; the RAM writes on the same rising edge.
REQ-010 mem_q  input  DATA_WIDTH  RAM read data, combinational from mem_addr in the same cycle.
REQ-011 in_data  input  DATA_WIDTH  input-port word.
REQ-012 in_valid  input  1  in_data is valid.
REQ-013 in_ready  output  1  io_exec consumes in_data this cycle.
REQ-014 out_data  output  DATA_WIDTH  output-port word.
REQ-015 out_valid  output  1  out_data is valid.
REQ-016 out_ready  input  1  sink accepts out_data.
REQ-017 halted  output  1  HLT has been executed.
REQ-018 trap  output  1  an illegal opcode was fetched (IO_EXEC_TRAP_EN only; otherwise tied 0).

Function
REQ-019 Instruction format: two words, opcode word at pc and operand address at pc+1; opcode = word[15:11].
REQ-020 Opcode encodings: IN = 5'b01011, OUT = 5'b01100, HLT = 5'b01111; all other values are illegal.
REQ-021 States: FETCH_OP, FETCH_ADR, IN_WAIT, OUT_RD, OUT_WAIT, HALT, TRAP.
REQ-022 FETCH_OP: mem_addr = pc. If run = 1, latch mem_q[15:11] as opcode, increment pc, and go to FETCH_ADR. If run = 0, hold.
REQ-023 HLT decode: HLT is decoded in FETCH_ADR and goes to HALT; its operand word is still fetched and pc is still incremented.
REQ-024 FETCH_ADR: mem_addr = pc; latch mem_q as operand and increment pc. Next state: IN to IN_WAIT, OUT to OUT_RD, HLT to HALT, illegal per REQ-035/036.
REQ-025 IN_WAIT handshake: in_ready = 1. On a cycle with in_valid = 1: mem_addr = operand, mem_wdata = in_data, mem_we = 1, and go to FETCH_OP. Otherwise hold with mem_we = 0.
REQ-026 OUT_RD: mem_addr = operand; latch mem_q into out_data, set out_valid = 1 from the next cycle, and go to OUT_WAIT.
REQ-027 OUT_WAIT: out_valid and out_data held stable until out_ready = 1. On that cycle, clear out_valid on the next edge and go to FETCH_OP.
REQ-028 HALT: halted = 1; mem_we = 0; remains until reset; run is ignored.
REQ-029 mem_we is asserted only in IN_WAIT with in_valid = 1; it is 0 in every other state and cycle.
REQ-030 pc wraps from 2^ADDR_WIDTH-1 to 0 without a flag, including when an operand fetch crosses the wrap.
REQ-031 in_ready and out_valid are never both 1 in the same cycle.
REQ-032 Instruction latency at zero wait: IN takes 3 cycles (FETCH_OP, FETCH_ADR, IN_WAIT); OUT takes 4 cycles (FETCH_OP, FETCH_ADR, OUT_RD, OUT_WAIT with out_ready = 1).

Reset
REQ-033 Reset assertion (rst_n = 0): immediately sets state = FETCH_OP, pc = START_ADDR, opcode = 0, operand = 0, out_data = 0, out_valid = 0, halted = 0, trap = 0, mem_we = 0.
REQ-034 Reset in mid-operation: a reset asserted in IN_WAIT or OUT_WAIT aborts the transfer with no RAM write and no held out_valid; execution restarts at START_ADDR on the first edge after release.

Configuration
REQ-035 With macro IO_EXEC_TRAP_EN defined: an illegal opcode moves FETCH_ADR to TRAP; TRAP sets trap = 1 and holds until reset, with pc pointing after the operand.
REQ-036 Without IO_EXEC_TRAP_EN: an illegal opcode is a 2-word NOP (FETCH_ADR to FETCH_OP); no trap state logic exists and trap = 0.

Verification
REQ-037 IN test: RAM words 0..1 = 16'h5800, 16'd100; in_valid = 1, in_data = 16'h00AB -> mem_we high in cycle 3 with mem_addr = 100, mem[100] = 16'h00AB.
REQ-038 OUT test: follow with OUT 100 (16'h6000, 16'd100) and out_ready held 0 for 5 cycles -> out_valid = 1, out_data = 16'h00AB stable; release -> out_valid clears one cycle after out_ready.
REQ-039 Full program test: four IN/OUT pairs on addresses 100..103 with HLT at word 16; inputs 1, 2, 3, 4 -> outputs 1, 2, 3, 4 in order; halted = 1; no further mem_we.
REQ-040 Wrap and reset test: START_ADDR = 16'hFFFF with the OUT opcode at 16'hFFFF and its operand at 0 -> operand read from address 0, next fetch at 1. Reset asserted in IN_WAIT -> no write, restart at START_ADDR.
REQ-041 Illegal-opcode test: opcode word 16'hF800 -> with IO_EXEC_TRAP_EN, trap = 1 and pc = 2; without it, execution continues at word 2.
